// File: rtl/memory_pkg.sv
// Shared constants, types and boot image for the CPU main memory.
package memory_pkg;

  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DEPTH  = 65536;

  typedef logic [MEM_DATA_W-1:0] mem_word_t;
  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;

  // Image values are 16 bits wide; the loader truncates them to the word width.
  typedef struct packed {
    mem_addr_t   addr;
    logic [15:0] value;
  } boot_entry_t;

  localparam int unsigned BOOT_LEN = 5;

  localparam boot_entry_t BOOT_IMAGE [BOOT_LEN] = '{
    '{addr: 16'd1,  value: 16'd12},
    '{addr: 16'd3,  value: 16'd14},
    '{addr: 16'd5,  value: 16'd16},
    '{addr: 16'd12, value: 16'd10},
    '{addr: 16'd14, value: 16'd5}
  };

endpackage

// File: rtl/memory_array.sv
// Inferable single-port RAM core: synchronous write, asynchronous read,
// preloaded from the built-in boot image.
module memory_array
  import memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DATA_W,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Configuration-time contents; the array is never cleared afterwards.
  initial begin
    for (int unsigned i = 0; i < Depth; i++) begin
      mem[i] = '0;
    end
    for (int unsigned i = 0; i < BOOT_LEN; i++) begin
      if (32'(BOOT_IMAGE[i].addr) < Depth) begin
        mem[ADDR_WIDTH'(BOOT_IMAGE[i].addr)] = DATA_WIDTH'(BOOT_IMAGE[i].value);
      end
    end
  end

  // Single write port; an unknown enable is treated as no write.
  always_ff @(posedge clk) begin
    if (writeEnable) begin
      mem[address] <= writeData;
    end
  end

  assign readData = mem[address];

endmodule

// File: rtl/memory_ram.sv
// 64K x 8 single-port RAM with a resettable registered read port and
// write-first behaviour.
module memory_ram
  import memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DATA_W,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memWrite,
  input  logic [ADDR_WIDTH-1:0] inputAddress,
  input  logic [DATA_WIDTH-1:0] inputValue,
  output logic [DATA_WIDTH-1:0] outputValue
);

  logic                  arrayWrite;
  logic [DATA_WIDTH-1:0] arrayRead;
  logic [DATA_WIDTH-1:0] outputNext;

  // A write whose edge lands while reset is held must be dropped.
  assign arrayWrite = memWrite & rst_n;

  memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk         (clk),
    .writeEnable (arrayWrite),
    .address     (inputAddress),
    .writeData   (inputValue),
    .readData    (arrayRead)
  );

  // Write-first bypass: a write returns its own data on the same edge.
  always_comb begin
    outputNext = arrayRead;
    if (memWrite) begin
      outputNext = inputValue;
    end
  end

  // Output register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outputValue <= '0;
    end else begin
      outputValue <= outputNext;
    end
  end

endmodule

// File: tb/tb_memory_ram.sv
// Directed scoreboard bench for memory_ram.
module tb_memory_ram;

  logic        clk;
  logic        rst_n;
  logic        memWrite;
  logic [15:0] inputAddress;
  logic [7:0]  inputValue;
  logic [7:0]  outputValue;

  int vectors;
  int miscompares;
  logic [7:0] expQ [$];

  memory_ram u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .memWrite     (memWrite),
    .inputAddress (inputAddress),
    .inputValue   (inputValue),
    .outputValue  (outputValue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic checkNow(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation per cycle: drive on the falling edge, compare just after the rising edge.
  task automatic doOp(input string tag, input logic we, input logic [15:0] addr,
                      input logic [7:0] din, input logic [7:0] exp, input bit check);
    logic [7:0] e;
    @(negedge clk);
    memWrite     = we;
    inputAddress = addr;
    inputValue   = din;
    if (check) expQ.push_back(exp);
    @(posedge clk);
    #1;
    if (check) begin
      e = expQ.pop_front();
      checkNow(tag, outputValue, e);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    memWrite     = 1'b0;
    inputAddress = '0;
    inputValue   = '0;

    #3;
    checkNow("reset_out", outputValue, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Boot image
    doOp("boot_0",  1'b0, 16'd0,  8'h00, 8'd0,  1'b1);
    doOp("boot_1",  1'b0, 16'd1,  8'h00, 8'd12, 1'b1);
    doOp("boot_3",  1'b0, 16'd3,  8'h00, 8'd14, 1'b1);
    doOp("boot_4",  1'b0, 16'd4,  8'h00, 8'd0,  1'b1);
    doOp("boot_5",  1'b0, 16'd5,  8'h00, 8'd16, 1'b1);
    doOp("boot_12", 1'b0, 16'd12, 8'h00, 8'd10, 1'b1);
    doOp("boot_14", 1'b0, 16'd14, 8'h00, 8'd5,  1'b1);

    // Write-first and read-after-write
    doOp("wr_first", 1'b1, 16'h0100, 8'hA5, 8'hA5, 1'b1);
    doOp("raw_read", 1'b0, 16'h0100, 8'h00, 8'hA5, 1'b1);
    doOp("read_2",   1'b0, 16'h0002, 8'h00, 8'h00, 1'b1);

    // Asynchronous reset mid-cycle, contents preserved
    doOp("pre_rst",  1'b0, 16'd1, 8'h00, 8'h0C, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkNow("async_rst", outputValue, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    doOp("post_rst", 1'b0, 16'd1, 8'h00, 8'd12, 1'b1);

    // Write attempted during reset is dropped
    @(negedge clk);
    rst_n        = 1'b0;
    memWrite     = 1'b1;
    inputAddress = 16'h0002;
    inputValue   = 8'h77;
    @(posedge clk);
    #1;
    checkNow("rst_hold", outputValue, 8'h00);
    @(negedge clk);
    memWrite = 1'b0;
    rst_n    = 1'b1;
    doOp("rst_nowr", 1'b0, 16'h0002, 8'h00, 8'h00, 1'b1);

    // Address extremes, no aliasing
    doOp("wr_ffff", 1'b1, 16'hFFFF, 8'h3C, 8'h3C, 1'b1);
    doOp("wr_0000", 1'b1, 16'h0000, 8'hC3, 8'hC3, 1'b1);
    doOp("rd_ffff", 1'b0, 16'hFFFF, 8'h00, 8'h3C, 1'b1);
    doOp("rd_0000", 1'b0, 16'h0000, 8'h00, 8'hC3, 1'b1);

    // Full fill, idle, sampled readback
    for (int i = 0; i < 65536; i++) begin
      doOp("fill", 1'b1, 16'(i), 8'h55, 8'h55, (i % 4096) == 0);
    end
    for (int i = 0; i < 180; i++) begin
      doOp("idle", 1'b0, 16'(i), 8'h00, 8'h55, 1'b0);
    end
    for (int i = 0; i < 65536; i += 97) begin
      doOp("readback", 1'b0, 16'(i), 8'h00, 8'h55, 1'b1);
    end
    doOp("readback_top", 1'b0, 16'hFFFF, 8'h00, 8'h55, 1'b1);
    doOp("readback_1",   1'b0, 16'h0001, 8'h00, 8'h55, 1'b1);

    checkNow("queue_empty", 8'(expQ.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
